// File: rtl/softmax_pkg.sv
// Shared types and helpers for the fixed-point softmax control path.
package softmax_pkg;

    // Two-pass schedule: clear, fill buffer + accumulate, reciprocal, drain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RECIP = 2'd2,
        DRAIN = 2'd3
    } softmax_state_t;

    // Buffer address width: ceil(log2(depth)), never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        int unsigned w;
        if (depth <= 1) begin
            w = 1;
        end else begin
            w = $clog2(depth);
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-DEPTH slot counter: advances on inc, returns to 0 after DEPTH-1.
module mod_counter
    import softmax_pkg::*;
#(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LastSlot = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] count_q;

    // wrap flags the terminal slot so the owner knows this inc ends the pass
    always_comb begin
        count = count_q;
        wrap  = (count_q == LastSlot);
    end

    // Counter never passes DEPTH-1; with DEPTH=1 it stays at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            if (wrap) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_softmax_ctrl.sv
// Sequencing controller for the fixed-point softmax datapath. Owns every
// enable, address and handshake of the exp buffer, accumulator and divider.
module fixed_softmax_ctrl
    import softmax_pkg::*;
#(
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned ADDR_WIDTH = addr_w(DEPTH),
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream block stream
    input  logic                  data_in_0_valid,
    output logic                  data_in_0_ready,
    // exp buffer write side and accumulator
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic                  acc_clear,
    output logic                  acc_en,
    // reciprocal / divider
    output logic                  recip_start,
    input  logic                  recip_done,
    // exp buffer read side and output stream
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    output logic                  data_out_0_valid,
    input  logic                  data_out_0_ready,
    output logic                  data_out_0_last,
    // status
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  vec_count
);

    softmax_state_t        state_q;
    logic                  recip_start_q;
    logic [CNT_WIDTH-1:0]  vec_count_q;

    logic                  in_hs;
    logic                  out_hs;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic                  wr_wrap;
    logic                  rd_wrap;

    // Handshakes are only possible in their own pass, so the buffer cannot overrun.
    always_comb begin
        in_hs  = (state_q == FILL) && data_in_0_valid;
        out_hs = (state_q == DRAIN) && data_out_0_ready;
    end

    mod_counter #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_hs),
        .count (wr_cnt),
        .wrap  (wr_wrap)
    );

    mod_counter #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_hs),
        .count (rd_cnt),
        .wrap  (rd_wrap)
    );

    // Schedule FSM; recip_start_q doubles as the "first RECIP cycle" marker,
    // which masks a recip_done left high from before the divider was started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            recip_start_q <= 1'b0;
            vec_count_q   <= '0;
        end else begin
            recip_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q <= FILL;
                end
                FILL: begin
                    if (in_hs && wr_wrap) begin
                        state_q       <= RECIP;
                        recip_start_q <= 1'b1;
                    end
                end
                RECIP: begin
                    if (!recip_start_q && recip_done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_hs && rd_wrap) begin
                        state_q     <= IDLE;
                        vec_count_q <= vec_count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state and counters; addresses park at 0 when unused.
    always_comb begin
        data_in_0_ready  = (state_q == FILL);
        buf_wr_en        = in_hs;
        acc_en           = in_hs;
        buf_wr_addr      = (state_q == FILL) ? wr_cnt : '0;
        acc_clear        = (state_q == IDLE);
        recip_start      = recip_start_q;
        data_out_0_valid = (state_q == DRAIN);
        buf_rd_addr      = (state_q == DRAIN) ? rd_cnt : '0;
        data_out_0_last  = (state_q == DRAIN) && rd_wrap;
        busy             = (state_q != IDLE);
        vec_count        = vec_count_q;
    end

endmodule

// File: tb/tb_fixed_softmax_ctrl.sv
// Bench for fixed_softmax_ctrl: a DEPTH=4 instance driven from a vector table
// plus a reset-mid-drain sequence, and a DEPTH=1 / CNT_WIDTH=2 instance run
// back-to-back to cover the single-block case and vec_count wrap.
module tb_fixed_softmax_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: DEPTH=4 ----------------
    logic        rst_a;
    logic        in_valid_a, in_ready_a, wr_en_a, acc_clear_a, acc_en_a;
    logic        recip_start_a, done_a, out_valid_a, out_ready_a, last_a, busy_a;
    logic [1:0]  wr_addr_a, rd_addr_a;
    logic [15:0] vec_a;

    fixed_softmax_ctrl #(
        .DEPTH     (4),
        .CNT_WIDTH (16)
    ) u_dut_a (
        .clk              (clk),
        .rst              (rst_a),
        .data_in_0_valid  (in_valid_a),
        .data_in_0_ready  (in_ready_a),
        .buf_wr_en        (wr_en_a),
        .buf_wr_addr      (wr_addr_a),
        .acc_clear        (acc_clear_a),
        .acc_en           (acc_en_a),
        .recip_start      (recip_start_a),
        .recip_done       (done_a),
        .buf_rd_addr      (rd_addr_a),
        .data_out_0_valid (out_valid_a),
        .data_out_0_ready (out_ready_a),
        .data_out_0_last  (last_a),
        .busy             (busy_a),
        .vec_count        (vec_a)
    );

    // ---------------- DUT B: DEPTH=1, CNT_WIDTH=2 ----------------
    logic       rst_b;
    logic       in_valid_b, in_ready_b, wr_en_b, acc_clear_b, acc_en_b;
    logic       recip_start_b, done_b, out_valid_b, out_ready_b, last_b, busy_b;
    logic [0:0] wr_addr_b, rd_addr_b;
    logic [1:0] vec_b;

    fixed_softmax_ctrl #(
        .DEPTH     (1),
        .CNT_WIDTH (2)
    ) u_dut_b (
        .clk              (clk),
        .rst              (rst_b),
        .data_in_0_valid  (in_valid_b),
        .data_in_0_ready  (in_ready_b),
        .buf_wr_en        (wr_en_b),
        .buf_wr_addr      (wr_addr_b),
        .acc_clear        (acc_clear_b),
        .acc_en           (acc_en_b),
        .recip_start      (recip_start_b),
        .recip_done       (done_b),
        .buf_rd_addr      (rd_addr_b),
        .data_out_0_valid (out_valid_b),
        .data_out_0_ready (out_ready_b),
        .data_out_0_last  (last_b),
        .busy             (busy_b),
        .vec_count        (vec_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q_a[$];
    int q_b[$];

    typedef struct {
        int         delay;      // RECIP cycle index at which recip_done rises (>=1)
        bit         early;      // recip_done also high during FILL and first RECIP cycle
        logic [7:0] rdy_pat;    // ready per DRAIN cycle, bit 0 first
        int         rdy_len;    // pattern length; ready=1 afterwards
        int         exp_period; // cycles from IDLE to the next IDLE
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One full vector on DUT A starting at its IDLE cycle. abort_after>0 stops
    // right after that many output handshakes, leaving the DUT mid-DRAIN.
    task automatic run_vector(input vec_t v, input int abort_after, input int exp_vec);
        int cyc = 0;
        int hs  = 0;
        int rd  = 0;
        int t   = 0;
        int exp_addr;
        // IDLE
        @(negedge clk);
        in_valid_a = 1'b0; done_a = v.early; out_ready_a = 1'b0;
        #1;
        check("idle_acc_clear", acc_clear_a, 1);
        check("idle_busy", busy_a, 0);
        check("idle_in_ready", in_ready_a, 0);
        check("idle_vec_count", vec_a, exp_vec);
        cyc++;
        // FILL, one block per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid_a = 1'b1; done_a = v.early;
            #1;
            check("fill_in_ready", in_ready_a, 1);
            check("fill_wr_en", wr_en_a, 1);
            check("fill_acc_en", acc_en_a, 1);
            check("fill_wr_addr", wr_addr_a, i);
            check("fill_acc_clear", acc_clear_a, 0);
            check("fill_recip_start", recip_start_a, 0);
            q_a.push_back(i);
            cyc++;
        end
        // RECIP; upstream keeps offering to prove nothing is accepted
        for (int k = 0; k <= v.delay; k++) begin
            @(negedge clk);
            in_valid_a = 1'b1;
            done_a = (k == 0) ? v.early : (k >= v.delay);
            #1;
            check("recip_start_pulse", recip_start_a, (k == 0) ? 1 : 0);
            check("recip_in_ready", in_ready_a, 0);
            check("recip_wr_en", wr_en_a, 0);
            check("recip_out_valid", out_valid_a, 0);
            check("recip_busy", busy_a, 1);
            cyc++;
        end
        // DRAIN
        while (hs < 4 && t < 40) begin
            @(negedge clk);
            in_valid_a = 1'b1; done_a = 1'b0;
            out_ready_a = (t < v.rdy_len) ? v.rdy_pat[t] : 1'b1;
            #1;
            check("drain_valid", out_valid_a, 1);
            check("drain_rd_addr", rd_addr_a, rd);
            check("drain_last", last_a, (rd == 3) ? 1 : 0);
            check("drain_in_ready", in_ready_a, 0);
            if (out_ready_a) begin
                if (q_a.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_addr = q_a.pop_front();
                    check("sb_rd_addr", rd_addr_a, exp_addr);
                end
                hs++;
                rd++;
            end
            t++;
            cyc++;
            if (abort_after != 0 && hs == abort_after) begin
                return;
            end
        end
        check("drain_handshakes", hs, 4);
        check("vector_period", cyc, v.exp_period);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{delay: 3,  early: 1'b0, rdy_pat: 8'hFF, rdy_len: 0, exp_period: 13};
        vecs[1] = '{delay: 1,  early: 1'b0, rdy_pat: 8'hFF, rdy_len: 0, exp_period: 11};
        vecs[2] = '{delay: 1,  early: 1'b1, rdy_pat: 8'hFF, rdy_len: 0, exp_period: 11};
        vecs[3] = '{delay: 20, early: 1'b1, rdy_pat: 8'hFF, rdy_len: 0, exp_period: 30};
        vecs[4] = '{delay: 2,  early: 1'b0, rdy_pat: 8'h59, rdy_len: 7, exp_period: 15};

        rst_a = 1'b1; in_valid_a = 1'b0; done_a = 1'b0; out_ready_a = 1'b0;
        rst_b = 1'b1; in_valid_b = 1'b0; done_b = 1'b0; out_ready_b = 1'b0;
        #2;
        check("rst_acc_clear", acc_clear_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_recip_start", recip_start_a, 0);
        check("rst_vec_count", vec_a, 0);
        check("rst_b_acc_clear", acc_clear_b, 1);
        check("rst_b_busy", busy_b, 0);

        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i], 0, i);
        end

        // Reset after two outputs of the sixth vector
        run_vector(vecs[0], 2, 5);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("midrst_acc_clear", acc_clear_a, 1);
        check("midrst_out_valid", out_valid_a, 0);
        check("midrst_rd_addr", rd_addr_a, 0);
        check("midrst_last", last_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_recip_start", recip_start_a, 0);
        check("midrst_vec_count", vec_a, 0);
        q_a.delete();
        @(posedge clk);
        #1 rst_a = 1'b0;
        run_vector(vecs[1], 0, 0);
        @(negedge clk);
        in_valid_a = 1'b0;
        #1;
        check("post_drain_acc_clear", acc_clear_a, 1);
        check("post_drain_vec_count", vec_a, 1);
        rst_a = 1'b1;

        // DEPTH=1 back-to-back, recip_done tied high: period 5, count wraps at 4
        @(posedge clk);
        #1;
        rst_b = 1'b0; in_valid_b = 1'b1; done_b = 1'b1; out_ready_b = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            int ph;
            int e;
            ph = c % 5;
            @(negedge clk);
            #1;
            unique case (ph)
                0: begin
                    check("d1_idle_acc_clear", acc_clear_b, 1);
                    check("d1_idle_busy", busy_b, 0);
                    check("d1_vec_count", vec_b, (c / 5) % 4);
                end
                1: begin
                    check("d1_wr_en", wr_en_b, 1);
                    check("d1_wr_addr", wr_addr_b, 0);
                    check("d1_in_ready", in_ready_b, 1);
                    q_b.push_back(0);
                end
                2: begin
                    check("d1_recip_start", recip_start_b, 1);
                    check("d1_recip_out_valid", out_valid_b, 0);
                end
                3: begin
                    check("d1_recip_start_off", recip_start_b, 0);
                    check("d1_recip2_out_valid", out_valid_b, 0);
                    check("d1_recip_in_ready", in_ready_b, 0);
                end
                default: begin
                    check("d1_out_valid", out_valid_b, 1);
                    check("d1_last", last_b, 1);
                    if (q_b.size() == 0) begin
                        check("d1_sb_underflow", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        check("d1_sb_rd_addr", rd_addr_b, e);
                    end
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
